elev_req_ctrl: RTL and testbench
================================

Name: elev_req_ctrl

Overview:
Upstream request controller for the 4-floor elevator fsm. It latches floor call-button pulses and decides travel direction with a SCAN policy. It issues single-cycle u/d step commands to fsm and reads back fsm's presState as cur_floor. At each served floor it holds a door-open dwell.

Parameters:
DWELL_CYCLES, 4, door-open duration in clk cycles; legal range 1..255.
NUM_FLOORS, 4, fixed to match state_t (S1..S4); not user-overridable.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
req  input  4  call-button pulses; bit i = floor i+1 (bit0=S1 .. bit3=S4)
cur_floor  input  state_t (2)  current floor; driven by fsm presState
u  output  1  step-up command to fsm; high for exactly one cycle per step
d  output  1  step-down command to fsm; high for exactly one cycle per step
door_open  output  1  high while dwelling at a served floor
pending  output  4  latched outstanding requests, same bit mapping as req
busy  output  1  high when state != EVAL or pending != 0

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. While rst=1: state=EVAL, pending=0, dir_up=1, dwell count=0, u=d=door_open=busy=0.
- Control states (ctrl_state_t): EVAL, STEP_UP, STEP_DOWN, DOOR.
- u = (state==STEP_UP) and d = (state==STEP_DOWN), decoded from the state register. u and d are never both 1.
- Request latch: pending_next = (pending | req) & ~clr.
  - clr = onehot(cur_floor) in the cycle EVAL selects DOOR and in every DOOR cycle.
  - A req for the current floor during DOOR is therefore dropped.
- EVAL decision, in priority order:
  1. pending[cur] or req[cur] set → DOOR.
  2. Above = any pending/req bit for a floor above cur; below = any for a floor below.
  3. above && (dir_up || !below) → STEP_UP, dir_up<=1.
  4. below → STEP_DOWN, dir_up<=0.
  5. Otherwise stay in EVAL; dir_up is retained.
- STEP_UP / STEP_DOWN: last exactly one cycle, then EVAL. fsm updates presState on that same edge, so EVAL sees the new floor. Floor-to-floor cadence is 2 cycles.
- Boundary guards:
  - Never enter STEP_UP at S4; never enter STEP_DOWN at S1. This holds even if corrupted pending bits would require it.
  - Illegal cur_floor encodings cannot occur with a 2-bit enum. Any unmatched case defaults to EVAL with u=d=0.
- DOOR:
  - On entry, the dwell counter loads DWELL_CYCLES-1. It decrements each cycle in DOOR.
  - At count 0, transition to EVAL.
  - door_open=1 for exactly DWELL_CYCLES cycles.
- Request latency: req pulse in cycle k is visible in pending at k+1. EVAL also acts on the raw req in cycle k.
- Simultaneous up/down demand with empty history: dir_up=1 after reset, so up is served first.
- Reset mid-operation (any state): outputs clear asynchronously, and all pending requests are lost.

Decomposition:
- fsm_pkg additions:
  - ctrl_state_t enum (EVAL, STEP_UP, STEP_DOWN, DOOR).
  - Function floor_onehot(state_t) returning a 4-bit one-hot.
  - Functions above_mask(state_t) and below_mask(state_t).
  - Localparam NUM_FLOORS=4.
- Sub-module dwell_timer (load, en, done; width $clog2(DWELL_CYCLES+1)), reset asynchronous active-high.

Test Plan:
(DWELL_CYCLES=4 for all scenarios)
1. Reset: rst=1 for 2 cycles with req=4'b1111 → u=d=door_open=0, pending=4'b0000, busy=0. Release rst at S1 with req=0 → all outputs stay 0.
2. At S1 (DUT fsm in loop), pulse req=4'b0100 for one cycle → pending=4'b0100 next cycle. u pulses twice, 2 cycles apart, and cur_floor reaches S3. door_open is high for exactly 4 cycles, then pending=4'b0000 and busy=0. d stays 0 throughout.
3. Idle at S1, pulse req=4'b0001 → no u/d, door_open high for 4 cycles. A second req=4'b0001 pulse during DOOR is dropped (pending stays 0000).
4. At S2 with dir_up=1, pulse req=4'b1001 → serves S4 first (door 4 cycles), then steps down 3 times to S1 and serves it. u and d are never high in the same cycle.
5. At S4, pulse req=4'b1000 then hold req=0 → no u ever asserted at S4; only door_open for 4 cycles. Repeat at S1 with req=4'b0001 → no d asserted.
6. Mid-DOOR at S3 with pending=4'b0001, assert rst asynchronously between edges → door_open, u and d drop before the next clk edge and pending=0. After release, the block idles in EVAL.

Source files
------------

// File: rtl/fsm_pkg.sv
// Shared types for the elevator floor fsm and its upstream request controller.
// Floor encoding S1..S4 maps to request bit 0..3.
package fsm_pkg;

    localparam int NUM_FLOORS = 4;

    typedef enum logic [1:0] {S1, S2, S3, S4} state_t;

    typedef enum logic [1:0] {EVAL, STEP_UP, STEP_DOWN, DOOR} ctrl_state_t;

    function automatic logic [NUM_FLOORS-1:0] floor_onehot(input state_t f);
        case (f)
            S1:      floor_onehot = 4'b0001;
            S2:      floor_onehot = 4'b0010;
            S3:      floor_onehot = 4'b0100;
            S4:      floor_onehot = 4'b1000;
            default: floor_onehot = 4'b0000;
        endcase
    endfunction

    function automatic logic [NUM_FLOORS-1:0] above_mask(input state_t f);
        case (f)
            S1:      above_mask = 4'b1110;
            S2:      above_mask = 4'b1100;
            S3:      above_mask = 4'b1000;
            default: above_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [NUM_FLOORS-1:0] below_mask(input state_t f);
        case (f)
            S2:      below_mask = 4'b0001;
            S3:      below_mask = 4'b0011;
            S4:      below_mask = 4'b0111;
            default: below_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/elev_req_ctrl_dwell_timer.sv
// Door-open dwell counter: load arms DWELL_CYCLES-1, en counts down, done at zero.
module dwell_timer #(
    parameter int DWELL_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_done
);
    localparam int W = $clog2(DWELL_CYCLES + 1);
    localparam logic [W-1:0] LOAD_VAL = W'(DWELL_CYCLES - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_en && r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/elev_req_ctrl.sv
// SCAN request controller: latches call pulses, steps the floor fsm one floor
// at a time with single-cycle u/d commands and dwells with the door open at served floors.
module elev_req_ctrl
    import fsm_pkg::*;
#(
    parameter int DWELL_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] req,
    input  state_t                cur_floor,
    output logic                  u,
    output logic                  d,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  busy
);
    ctrl_state_t           r_state;
    logic [NUM_FLOORS-1:0] r_pending;
    logic                  r_dir_up;

    logic [NUM_FLOORS-1:0] w_oh, w_all, w_clr;
    logic w_here, w_above, w_below, w_up_ok, w_dn_ok, w_enter_door, w_done;

    // Raw req is merged in so EVAL can act in the same cycle a button is pressed.
    assign w_oh    = floor_onehot(cur_floor);
    assign w_all   = r_pending | req;
    assign w_here  = |(w_all & w_oh);
    assign w_above = |(w_all & above_mask(cur_floor));
    assign w_below = |(w_all & below_mask(cur_floor));

    // Explicit end-of-shaft guards independent of the masks.
    assign w_up_ok = w_above && (r_dir_up || !w_below) && (cur_floor != S4);
    assign w_dn_ok = w_below && (cur_floor != S1);

    assign w_enter_door = (r_state == EVAL) && w_here;
    assign w_clr        = (w_enter_door || r_state == DOOR) ? w_oh : '0;

    dwell_timer #(
        .DWELL_CYCLES(DWELL_CYCLES)
    ) u_dwell (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_enter_door),
        .i_en   (r_state == DOOR),
        .o_done (w_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= EVAL;
            r_pending <= '0;
            r_dir_up  <= 1'b1;
        end else begin
            r_pending <= (r_pending | req) & ~w_clr;
            case (r_state)
                EVAL: begin
                    if (w_here) begin
                        r_state <= DOOR;
                    end else if (w_up_ok) begin
                        r_state  <= STEP_UP;
                        r_dir_up <= 1'b1;
                    end else if (w_dn_ok) begin
                        r_state  <= STEP_DOWN;
                        r_dir_up <= 1'b0;
                    end
                end
                STEP_UP, STEP_DOWN: r_state <= EVAL;
                DOOR:    if (w_done) r_state <= EVAL;
                default: r_state <= EVAL;
            endcase
        end
    end

    assign u         = (r_state == STEP_UP);
    assign d         = (r_state == STEP_DOWN);
    assign door_open = (r_state == DOOR);
    assign pending   = r_pending;
    assign busy      = (r_state != EVAL) || (r_pending != '0);

endmodule

// File: tb/tb_elev_req_ctrl.sv
// Directed bench for elev_req_ctrl with a behavioural floor fsm closing the u/d loop.
module tb_elev_req_ctrl;
    import fsm_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b1111;
    state_t     cur_floor = S1;
    logic       u, d, door_open, busy;
    logic [3:0] pending;

    logic       set_req = 1'b0;
    state_t     set_val = S1;

    int vec = 0;
    int errs = 0;

    elev_req_ctrl #(.DWELL_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .cur_floor (cur_floor),
        .u         (u),
        .d         (d),
        .door_open (door_open),
        .pending   (pending),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Floor fsm model: moves one floor on each u/d pulse, or is placed directly by a test.
    always @(posedge clk) begin
        if (set_req)                 cur_floor <= set_val;
        else if (u && cur_floor != S4) cur_floor <= state_t'(cur_floor + 2'd1);
        else if (d && cur_floor != S1) cur_floor <= state_t'(cur_floor - 2'd1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic place(input state_t f);
        set_val = f;
        set_req = 1'b1;
        tick();
        set_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        tick();
        tick();
        vec++;
        if ({u, d, door_open, busy} !== 4'b0000 || pending !== 4'b0000) begin
            errs++;
            $display("FAIL reset_hold: u=%b d=%b door=%b busy=%b pending=%b, want all 0", u, d, door_open, busy, pending);
        end
        req = 4'b0000;
        set_val = S1;
        set_req = 1'b1;
        tick();
        set_req = 1'b0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            vec++;
            if ({u, d, door_open, busy} !== 4'b0000 || pending !== 4'b0000) begin
                errs++;
                $display("FAIL reset_idle[%0d]: u=%b d=%b door=%b busy=%b pending=%b, want all 0", i, u, d, door_open, busy, pending);
            end
        end
    endtask

    task automatic test_step_up();
        int nu = 0, nd = 0, ndoor = 0, u1 = -1, u2 = -1;
        req = 4'b0100;
        tick();
        req = 4'b0000;
        vec++;
        if (pending !== 4'b0100) begin
            errs++;
            $display("FAIL up_pending_latch: got %b, want 0100", pending);
        end
        for (int i = 1; i <= 14; i++) begin
            if (u) begin
                nu++;
                if (u1 < 0) u1 = i; else u2 = i;
            end
            if (d) nd++;
            if (door_open) ndoor++;
            tick();
        end
        vec++;
        if (nu !== 2) begin errs++; $display("FAIL up_u_count: got %0d, want 2", nu); end
        vec++;
        if (u2 - u1 !== 2) begin errs++; $display("FAIL up_u_spacing: got %0d, want 2", u2 - u1); end
        vec++;
        if (nd !== 0) begin errs++; $display("FAIL up_d_count: got %0d, want 0", nd); end
        vec++;
        if (ndoor !== 4) begin errs++; $display("FAIL up_door_cycles: got %0d, want 4", ndoor); end
        vec++;
        if (cur_floor !== S3) begin errs++; $display("FAIL up_floor: got %0d, want %0d", cur_floor, S3); end
        vec++;
        if (pending !== 4'b0000 || busy !== 1'b0) begin
            errs++;
            $display("FAIL up_final: pending=%b busy=%b, want 0000/0", pending, busy);
        end
    endtask

    task automatic test_here_drop();
        int nmove = 0, ndoor = 0, npend = 0;
        place(S1);
        req = 4'b0001;
        tick();
        req = 4'b0000;
        for (int i = 1; i <= 10; i++) begin
            if (i == 2) req = 4'b0001;
            if (i == 3) req = 4'b0000;
            if (u || d) nmove++;
            if (door_open) ndoor++;
            if (i >= 3 && pending != 4'b0000) npend++;
            tick();
        end
        vec++;
        if (nmove !== 0) begin errs++; $display("FAIL here_moves: got %0d, want 0", nmove); end
        vec++;
        if (ndoor !== 4) begin errs++; $display("FAIL here_door_cycles: got %0d, want 4", ndoor); end
        vec++;
        if (npend !== 0) begin errs++; $display("FAIL here_drop: pending nonzero in %0d cycles, want 0", npend); end
    endtask

    task automatic test_scan();
        int nu = 0, nd = 0, ndoor = 0, nboth = 0;
        state_t first_door = S1;
        logic seen = 1'b0;
        place(S2);
        req = 4'b1001;
        tick();
        req = 4'b0000;
        for (int i = 1; i <= 24; i++) begin
            if (u) nu++;
            if (d) nd++;
            if (u && d) nboth++;
            if (door_open) begin
                ndoor++;
                if (!seen) begin first_door = cur_floor; seen = 1'b1; end
            end
            tick();
        end
        vec++;
        if (first_door !== S4) begin errs++; $display("FAIL scan_first_served: got %0d, want %0d", first_door, S4); end
        vec++;
        if (nu !== 2 || nd !== 3) begin errs++; $display("FAIL scan_steps: u=%0d d=%0d, want 2/3", nu, nd); end
        vec++;
        if (nboth !== 0) begin errs++; $display("FAIL scan_u_and_d: got %0d cycles, want 0", nboth); end
        vec++;
        if (ndoor !== 8) begin errs++; $display("FAIL scan_door_cycles: got %0d, want 8", ndoor); end
        vec++;
        if (cur_floor !== S1 || pending !== 4'b0000 || busy !== 1'b0) begin
            errs++;
            $display("FAIL scan_final: floor=%0d pending=%b busy=%b, want 0/0000/0", cur_floor, pending, busy);
        end
    endtask

    task automatic test_boundary();
        int nu = 0, nd = 0, ndoor = 0;
        place(S4);
        req = 4'b1000;
        tick();
        req = 4'b0000;
        for (int i = 1; i <= 8; i++) begin
            if (u) nu++;
            if (d) nd++;
            if (door_open) ndoor++;
            tick();
        end
        vec++;
        if (nu !== 0 || nd !== 0 || ndoor !== 4) begin
            errs++;
            $display("FAIL top_boundary: u=%0d d=%0d door=%0d, want 0/0/4", nu, nd, ndoor);
        end
        nu = 0; nd = 0; ndoor = 0;
        place(S1);
        req = 4'b0001;
        tick();
        req = 4'b0000;
        for (int i = 1; i <= 8; i++) begin
            if (u) nu++;
            if (d) nd++;
            if (door_open) ndoor++;
            tick();
        end
        vec++;
        if (nu !== 0 || nd !== 0 || ndoor !== 4) begin
            errs++;
            $display("FAIL bottom_boundary: u=%0d d=%0d door=%0d, want 0/0/4", nu, nd, ndoor);
        end
    endtask

    task automatic test_async_reset();
        int nact = 0;
        place(S3);
        req = 4'b0101;
        tick();
        req = 4'b0000;
        vec++;
        if (door_open !== 1'b1 || pending !== 4'b0001) begin
            errs++;
            $display("FAIL mid_door_setup: door=%b pending=%b, want 1/0001", door_open, pending);
        end
        tick();
        #2;
        rst = 1'b1;
        #1;
        vec++;
        if ({u, d, door_open, busy} !== 4'b0000 || pending !== 4'b0000) begin
            errs++;
            $display("FAIL async_reset: u=%b d=%b door=%b busy=%b pending=%b, want all 0", u, d, door_open, busy, pending);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (u || d || door_open || busy || pending != 4'b0000) nact++;
        end
        vec++;
        if (nact !== 0) begin errs++; $display("FAIL post_reset_idle: active in %0d cycles, want 0", nact); end
    endtask

    initial begin
        test_reset();
        test_step_up();
        test_here_drop();
        test_scan();
        test_boundary();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
